// File: rtl/maze_pkg.sv
// Shared types for the maze walker: move directions, controller states and the
// direction-reversal helper used when backtracking.
package maze_pkg;

   typedef enum logic [1:0] {
      DIR_PX = 2'd0,
      DIR_PY = 2'd1,
      DIR_NX = 2'd2,
      DIR_NY = 2'd3
   } dir_t;

   typedef enum logic [3:0] {
      IDLE,
      MARK,
      PROBE,
      RD,
      WR,
      BACK,
      DONE,
      FAIL,
      REPLAY
   } state_t;

   // Directions are laid out so that the reverse move only flips bit 1.
   function automatic dir_t opposite(input dir_t d);
      return dir_t'(d ^ 2'b10);
   endfunction

endpackage

// File: rtl/dir_stack.sv
// LIFO of 2-bit move directions with an extra indexed read port, so the
// solution path can be replayed from the bottom without disturbing the stack.
module dir_stack
   import maze_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          i_clear,
   input  logic          i_push,
   input  logic          i_pop,
   input  dir_t          i_data,
   input  logic [CW-1:0] i_rdIdx,
   output dir_t          o_top,
   output dir_t          o_rdData,
   output logic          o_full,
   output logic          o_empty,
   output logic [CW-1:0] o_count
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   dir_t          r_mem [DEPTH];
   logic [CW-1:0] r_count;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_top   = r_mem[IW'(r_count - 1'b1)];
   assign o_rdData = r_mem[IW'(i_rdIdx)];

   always_ff @(posedge Clk) begin
      if (Rst || i_clear) begin
         r_count <= '0;
      end else if (i_push && !o_full) begin
         r_count <= r_count + 1'b1;
      end else if (i_pop && !o_empty) begin
         r_count <= r_count - 1'b1;
      end
   end

   // Storage needs no reset: only entries below r_count are ever observed.
   always_ff @(posedge Clk) begin
      if (i_push && !o_full && !i_clear) begin
         r_mem[IW'(r_count)] <= i_data;
      end
   end

endmodule

// File: rtl/maze_walker.sv
// Depth-first maze solver driving an external 1-bit maze memory, with replay of
// the found path. Define MAZE_STEP_CNT_EN to add the saturating 'steps' output.
module maze_walker
   import maze_pkg::*;
#(
   parameter int X_W   = 2,
   parameter int Y_W   = 2,
   parameter int DEPTH = 16
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               Start,
   input  logic               Run,
   output logic               mem_rd,
   output logic               mem_wr,
   output logic [X_W+Y_W-1:0] mem_addr,
   output logic               mem_din,
   input  logic               mem_dout,
   input  logic               mem_ack,
   output logic [1:0]         dir,
   output logic               dir_valid,
   input  logic               dir_ready,
   output logic               Done,
   output logic               Fail,
`ifdef MAZE_STEP_CNT_EN
   output logic [15:0]        steps,
`endif
   output logic [X_W-1:0]     X,
   output logic [Y_W-1:0]     Y
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [X_W-1:0] X_MAX = '1;
   localparam logic [Y_W-1:0] Y_MAX = '1;

   state_t         r_state, w_nextState;
   logic [X_W-1:0] r_x, w_nextX, w_stepX;
   logic [Y_W-1:0] r_y, w_nextY, w_stepY;
   logic [2:0]     r_cand, w_nextCand;
   logic [CW-1:0]  r_ptr, w_nextPtr;
   logic           w_inBounds, w_start, w_push, w_pop, w_clear;
   logic           w_full, w_empty;
   logic [CW-1:0]  w_count;
   dir_t           w_stepDir, w_top, w_rdData;

   assign w_start   = Start && (r_state == IDLE || r_state == DONE || r_state == FAIL);
   assign w_stepDir = (r_state == BACK) ? opposite(w_top) : dir_t'(r_cand[1:0]);

   // One shared neighbour calculator serves both forward probes and backtracks.
   always_comb begin
      w_stepX    = r_x;
      w_stepY    = r_y;
      w_inBounds = 1'b0;
      case (w_stepDir)
         DIR_PX: begin w_stepX = r_x + 1'b1; w_inBounds = (r_x != X_MAX); end
         DIR_PY: begin w_stepY = r_y + 1'b1; w_inBounds = (r_y != Y_MAX); end
         DIR_NX: begin w_stepX = r_x - 1'b1; w_inBounds = (r_x != '0);    end
         DIR_NY: begin w_stepY = r_y - 1'b1; w_inBounds = (r_y != '0);    end
         default: ;
      endcase
   end

   dir_stack #(.DEPTH(DEPTH)) u_stack (
      .Clk      (Clk),
      .Rst      (Rst),
      .i_clear  (w_clear),
      .i_push   (w_push),
      .i_pop    (w_pop),
      .i_data   (dir_t'(r_cand[1:0])),
      .i_rdIdx  (r_ptr),
      .o_top    (w_top),
      .o_rdData (w_rdData),
      .o_full   (w_full),
      .o_empty  (w_empty),
      .o_count  (w_count)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_cand  <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_nextState;
         r_x     <= w_nextX;
         r_y     <= w_nextY;
         r_cand  <= w_nextCand;
         r_ptr   <= w_nextPtr;
      end
   end

   // Memory requests are pure functions of state, so they stay stable until ack.
   always_comb begin
      w_nextState = r_state;
      w_nextX     = r_x;
      w_nextY     = r_y;
      w_nextCand  = r_cand;
      w_nextPtr   = r_ptr;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_clear     = 1'b0;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = {r_y, r_x};
      dir_valid   = 1'b0;
      dir         = 2'd0;
      if (w_start) begin
         w_clear     = 1'b1;
         w_nextX     = '0;
         w_nextY     = '0;
         w_nextCand  = '0;
         w_nextState = MARK;
      end else begin
         case (r_state)
            DONE: begin
               if (Run && !w_empty) begin
                  w_nextPtr   = '0;
                  w_nextState = REPLAY;
               end
            end
            MARK: begin
               mem_wr = 1'b1;
               if (mem_ack) begin
                  w_nextState = (r_x == X_MAX && r_y == Y_MAX) ? DONE : PROBE;
               end
            end
            PROBE: begin
               if (r_cand == 3'd4) begin
                  w_nextState = BACK;
               end else if (!w_inBounds) begin
                  w_nextCand = r_cand + 3'd1;
               end else begin
                  w_nextState = RD;
               end
            end
            RD: begin
               mem_rd   = 1'b1;
               mem_addr = {w_stepY, w_stepX};
               if (mem_ack) begin
                  if (mem_dout) begin
                     w_nextCand  = r_cand + 3'd1;
                     w_nextState = PROBE;
                  end else if (w_full) begin
                     w_nextState = FAIL;
                  end else begin
                     w_push      = 1'b1;
                     w_nextX     = w_stepX;
                     w_nextY     = w_stepY;
                     w_nextCand  = '0;
                     w_nextState = MARK;
                  end
               end
            end
            BACK: begin
               if (w_empty) begin
                  w_nextState = FAIL;
               end else begin
                  w_pop       = 1'b1;
                  w_nextX     = w_stepX;
                  w_nextY     = w_stepY;
                  w_nextCand  = {1'b0, w_top} + 3'd1;
                  w_nextState = PROBE;
               end
            end
            REPLAY: begin
               dir_valid = 1'b1;
               dir       = w_rdData;
               if (dir_ready) begin
                  w_nextPtr = r_ptr + 1'b1;
                  if (r_ptr + 1'b1 == w_count) begin
                     w_nextState = DONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MAZE_STEP_CNT_EN
   logic [15:0] r_steps;

   always_ff @(posedge Clk) begin
      if (Rst || w_start) begin
         r_steps <= '0;
      end else if ((w_push || w_pop) && r_steps != 16'hFFFF) begin
         r_steps <= r_steps + 16'd1;
      end
   end

   assign steps = r_steps;
`endif

   assign mem_din = 1'b1;
   assign Done    = (r_state == DONE);
   assign Fail    = (r_state == FAIL);
   assign X       = r_x;
   assign Y       = r_y;

endmodule

// File: tb/tb_maze_walker.sv
// Directed bench for maze_walker: a 4x4 maze memory model with programmable ack
// latency, a replay scoreboard, and a second DEPTH=2 instance for stack overflow.
module tb_maze_walker;
   import maze_pkg::*;

   logic Clk = 1'b0;
   logic Rst, startPulse, runPulse, dirReady, selDut;
   logic memAck = 1'b0;
   logic memDout = 1'b0;
   logic start1, start2, run1, run2, ack1, ack2;

   logic       rd1, wr1, din1, dirValid1, done1, fail1;
   logic [3:0] addr1;
   logic [1:0] dir1, x1, y1;
   logic       rd2, wr2, din2, dirValid2, done2, fail2;
   logic [3:0] addr2;
   logic [1:0] dir2, x2, y2;
`ifdef MAZE_STEP_CNT_EN
   logic [15:0] steps1, steps2;
`endif

   bit         walls [16];
   bit         visited [16];
   bit         clearVisited = 1'b0;
   int         ackDelay = 0;
   int         waitCnt = 0;
   int         rdCount = 0;
   int         wrCount = 0;
   logic [3:0] heldAddr;
   logic [1:0] heldReq;

   int checkCount = 0;
   int passCount = 0;
   int failCount = 0;
   int rdBase, wrBase;

   logic [1:0] expQ [$];
   logic [1:0] pathFree [6]   = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
   logic [1:0] pathDetour [6] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1};

   assign start1 = startPulse & ~selDut;
   assign start2 = startPulse & selDut;
   assign run1   = runPulse & ~selDut;
   assign run2   = runPulse & selDut;
   assign ack1   = memAck & ~selDut;
   assign ack2   = memAck & selDut;

   always #5 Clk = ~Clk;

   maze_walker #(.X_W(2), .Y_W(2), .DEPTH(16)) u_dut (
      .Clk(Clk), .Rst(Rst), .Start(start1), .Run(run1),
      .mem_rd(rd1), .mem_wr(wr1), .mem_addr(addr1), .mem_din(din1),
      .mem_dout(memDout), .mem_ack(ack1),
      .dir(dir1), .dir_valid(dirValid1), .dir_ready(dirReady),
      .Done(done1), .Fail(fail1),
`ifdef MAZE_STEP_CNT_EN
      .steps(steps1),
`endif
      .X(x1), .Y(y1)
   );

   maze_walker #(.X_W(2), .Y_W(2), .DEPTH(2)) u_dut2 (
      .Clk(Clk), .Rst(Rst), .Start(start2), .Run(run2),
      .mem_rd(rd2), .mem_wr(wr2), .mem_addr(addr2), .mem_din(din2),
      .mem_dout(memDout), .mem_ack(ack2),
      .dir(dir2), .dir_valid(dirValid2), .dir_ready(dirReady),
      .Done(done2), .Fail(fail2),
`ifdef MAZE_STEP_CNT_EN
      .steps(steps2),
`endif
      .X(x2), .Y(y2)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic reportTimeout(input string tag);
      checkCount++;
      failCount++;
      $error("[TB] FAIL %s: observed timeout expected event", tag);
   endtask

   // Memory model: answers the selected DUT after ackDelay wait cycles and
   // checks that the request stays put while it waits.
   always @(negedge Clk) begin : memModel
      logic       reqRd, reqWr, reqDin;
      logic [3:0] reqAddr;
      reqRd   = selDut ? rd2 : rd1;
      reqWr   = selDut ? wr2 : wr1;
      reqDin  = selDut ? din2 : din1;
      reqAddr = selDut ? addr2 : addr1;
      if (clearVisited) visited = '{default: 1'b0};
      if (Rst || !(reqRd || reqWr)) begin
         memAck  = 1'b0;
         waitCnt = 0;
      end else begin
         checkOutput("rdWrExclusive", {31'd0, reqRd & reqWr}, 32'd0);
         if (waitCnt > 0) begin
            checkOutput("addrStable", {28'd0, reqAddr}, {28'd0, heldAddr});
            checkOutput("reqStable", {30'd0, reqRd, reqWr}, {30'd0, heldReq});
         end else begin
            heldAddr = reqAddr;
            heldReq  = {reqRd, reqWr};
         end
         if (waitCnt == ackDelay) begin
            memAck  = 1'b1;
            memDout = walls[reqAddr] | visited[reqAddr];
            waitCnt = 0;
            if (reqWr) begin
               checkOutput("memDin", {31'd0, reqDin}, 32'd1);
               visited[reqAddr] = 1'b1;
               wrCount++;
            end else begin
               rdCount++;
            end
         end else begin
            memAck = 1'b0;
            waitCnt++;
         end
      end
   end

   task automatic applyStimulus(input bit doStart, input bit doRun);
      @(negedge Clk);
      startPulse = doStart;
      runPulse   = doRun;
      @(negedge Clk);
      startPulse = 1'b0;
      runPulse   = 1'b0;
   endtask

   task automatic setupMaze(input logic [15:0] mask, input int delay);
      for (int i = 0; i < 16; i++) walls[i] = mask[i];
      ackDelay     = delay;
      clearVisited = 1'b1;
      @(negedge Clk);
      @(posedge Clk);
      clearVisited = 1'b0;
      @(negedge Clk);
      rdBase = rdCount;
      wrBase = wrCount;
   endtask

   task automatic waitOutcome(input string tag);
      int n = 0;
      while (!(selDut ? (done2 | fail2) : (done1 | fail1)) && n < 3000) begin
         @(negedge Clk);
         n++;
      end
      if (n >= 3000) reportTimeout(tag);
   endtask

   // Expected directions are already queued; pops happen on each handshake.
   task automatic checkReplay(input int n, input bit stallMode);
      int cycle = 0;
      int first = -1;
      int last = -1;
      int got = 0;
      logic [1:0] exp;
      @(negedge Clk);
      runPulse = 1'b1;
      dirReady = 1'b0;
      while (got < n && cycle < 200) begin
         @(negedge Clk);
         runPulse = 1'b0;
         cycle++;
         dirReady = stallMode ? (cycle % 3 != 0) : 1'b1;
         if (dirValid1 && dirReady) begin
            exp = expQ.pop_front();
            checkOutput("replayDir", {30'd0, dir1}, {30'd0, exp});
            if (first < 0) first = cycle;
            last = cycle;
            got++;
         end
      end
      if (got < n) reportTimeout("replayHandshakes");
      if (!stallMode) checkOutput("replayBurst", last - first, n - 1);
      @(negedge Clk);
      dirReady = 1'b0;
      checkOutput("replayEnd", {30'd0, dirValid1, done1}, 32'b01);
      checkOutput("replayQueueEmpty", expQ.size(), 0);
   endtask

   initial begin
      Rst        = 1'b1;
      startPulse = 1'b0;
      runPulse   = 1'b0;
      dirReady   = 1'b0;
      selDut     = 1'b0;
      for (int i = 0; i < 16; i++) walls[i] = 1'b0;
      repeat (3) @(negedge Clk);
      checkOutput("resetOutputs", {rd1, wr1, addr1, dir1, dirValid1, done1, fail1, x1, y1}, 0);
      checkOutput("resetOutputsDut2", {rd2, wr2, addr2, dir2, dirValid2, done2, fail2, x2, y2}, 0);
      Rst = 1'b0;

      $display("[TB] free grid search and replay");
      setupMaze(16'h0000, 0);
      applyStimulus(1'b1, 1'b0);
      waitOutcome("freeGridOutcome");
      checkOutput("freeDone", {done1, fail1}, 2'b10);
      checkOutput("freePos", {x1, y1}, 4'b1111);
      checkOutput("freeReads", rdCount - rdBase, 6);
      checkOutput("freeWrites", wrCount - wrBase, 7);
`ifdef MAZE_STEP_CNT_EN
      checkOutput("freeSteps", steps1, 6);
`endif
      foreach (pathFree[i]) expQ.push_back(pathFree[i]);
      checkReplay(6, 1'b0);

      $display("[TB] walled start cell, Start and Run together");
      setupMaze(16'h0012, 0);
      applyStimulus(1'b1, 1'b1);
      checkOutput("startWinsOverRun", {dirValid1, done1, wr1}, 3'b001);
      waitOutcome("walledOutcome");
      checkOutput("walledFail", {done1, fail1}, 2'b01);
      checkOutput("walledPos", {x1, y1}, 4'b0000);
      checkOutput("walledReads", rdCount - rdBase, 2);
      checkOutput("walledWrites", wrCount - wrBase, 1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("runIgnoredInFail", {dirValid1, fail1}, 2'b01);

      $display("[TB] dead end with backtracking");
      setupMaze(16'h00C0, 0);
      applyStimulus(1'b1, 1'b0);
      waitOutcome("detourOutcome");
      checkOutput("detourDone", {done1, fail1}, 2'b10);
      checkOutput("detourPos", {x1, y1}, 4'b1111);
      checkOutput("detourReads", rdCount - rdBase, 13);
      checkOutput("detourWrites", wrCount - wrBase, 9);
`ifdef MAZE_STEP_CNT_EN
      checkOutput("detourSteps", steps1, 10);
`endif
      foreach (pathDetour[i]) expQ.push_back(pathDetour[i]);
      checkReplay(6, 1'b1);

      $display("[TB] dead end with 3-cycle ack latency");
      setupMaze(16'h00C0, 3);
      applyStimulus(1'b1, 1'b0);
      waitOutcome("slowOutcome");
      checkOutput("slowDone", {done1, fail1}, 2'b10);
      checkOutput("slowReads", rdCount - rdBase, 13);
      checkOutput("slowWrites", wrCount - wrBase, 9);
      foreach (pathDetour[i]) expQ.push_back(pathDetour[i]);
      checkReplay(6, 1'b0);

      $display("[TB] DEPTH=2 overflow");
      selDut = 1'b1;
      setupMaze(16'h0000, 0);
      applyStimulus(1'b1, 1'b0);
      waitOutcome("overflowOutcome");
      checkOutput("overflowFail", {done2, fail2}, 2'b01);
      checkOutput("overflowPos", {x2, y2}, 4'b1000);
      checkOutput("overflowReads", rdCount - rdBase, 3);
      checkOutput("overflowWrites", wrCount - wrBase, 3);
      selDut = 1'b0;

      $display("[TB] reset during a pending read");
      setupMaze(16'h0000, 3);
      applyStimulus(1'b1, 1'b0);
      begin
         int n = 0;
         while (!rd1 && n < 500) begin
            @(negedge Clk);
            n++;
         end
         if (n >= 500) reportTimeout("waitForRead");
      end
      Rst = 1'b1;
      @(posedge Clk);
      #1;
      checkOutput("midReadReset", {rd1, wr1, addr1, dir1, dirValid1, done1, fail1, x1, y1}, 0);
      @(negedge Clk);
      Rst = 1'b0;
      setupMaze(16'h0000, 0);
      applyStimulus(1'b1, 1'b0);
      waitOutcome("afterResetOutcome");
      checkOutput("afterResetDone", {done1, fail1}, 2'b10);
      checkOutput("afterResetPos", {x1, y1}, 4'b1111);
      checkOutput("afterResetReads", rdCount - rdBase, 6);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
